// File: rtl/reduce_pkg.sv
// Shared definitions for the reduce-unit ingress path: flit field positions,
// reduction opcode prefix, adder latency and the arbiter state encoding.
package reduce_pkg;

    localparam int FlitWidth     = 82;
    localparam int ChildrenWidth = 3;
    localparam int PacketWidth   = FlitWidth + ChildrenWidth;
    localparam int ValidBitPos   = FlitWidth - 1;
    localparam int ChildrenPos   = FlitWidth;
    localparam int TagPos        = 38;
    localparam int OpPos         = 32;
    localparam int AdderLatency  = 4;

    localparam logic [1:0] ReduceOpPrefix = 2'b11;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } arb_state_e;

    // A reduction flit is a valid flit whose op[3:2] carries the reduction prefix.
    function automatic logic is_reduction(input logic valid, input logic [1:0] op_hi);
        return valid && (op_hi == ReduceOpPrefix);
    endfunction

endpackage

// File: rtl/reduce_input_arbiter_if.sv
// Ingress FIFO heads/pops plus the registered flit handshake toward the reduce unit.
// master = arbiter side, slave = FIFOs and reduce unit side.
interface reduce_input_arbiter_if
    import reduce_pkg::*;
#(
    parameter int NumPorts = 4
);
    localparam int IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [NumPorts*PacketWidth-1:0] in_packet;
    logic [NumPorts-1:0]             in_empty;
    logic [NumPorts-1:0]             in_rd_en;
    logic [PacketWidth-1:0]          ru_packet;
    logic                            ru_valid;
    logic                            ru_ready;
    logic [IdxW-1:0]                 grant_port;

    modport master (
        input  in_packet, in_empty, ru_ready,
        output in_rd_en, ru_packet, ru_valid, grant_port
    );

    modport slave (
        output in_packet, in_empty, ru_ready,
        input  in_rd_en, ru_packet, ru_valid, grant_port
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter int NumPorts = 4,
    parameter int IdxW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic [NumPorts-1:0] req,
    input  logic [IdxW-1:0]     rr_ptr,
    output logic [NumPorts-1:0] grant_oh,
    output logic [IdxW-1:0]     grant_idx,
    output logic                found
);

    always_comb begin
        int k;
        // NOTE: every output gets a default first so no latch is inferred.
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        k         = 0;
        for (int i = 0; i < NumPorts; i++) begin
            k = (int'(rr_ptr) + i) % NumPorts;
            if (!found && req[k]) begin
                found       = 1'b1;
                grant_oh[k] = 1'b1;
                grant_idx   = IdxW'(k);
            end
        end
    end

endmodule

// File: rtl/reduce_input_arbiter.sv
// Round-robin ingress arbiter for the shared reduce unit with per-slot hazard hold-off.
// Optional per-port stall / hazard counters are enabled with `define REDUCE_ARB_STATS_EN.
module reduce_input_arbiter
    import reduce_pkg::*;
#(
    parameter int NumPorts   = 4,
    parameter int TagSlots   = 4,
    parameter int HoldCycles = AdderLatency + 2
) (
    input  logic clk,
    input  logic rst,
    reduce_input_arbiter_if.master bus
`ifdef REDUCE_ARB_STATS_EN
    ,
    output logic [NumPorts*16-1:0] stall_count,
    output logic [15:0]            hazard_block_count
`endif
);

    localparam int IdxW   = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int SlotW  = (TagSlots > 1) ? $clog2(TagSlots) : 1;
    localparam int TimerW = $clog2(HoldCycles + 1);

    arb_state_e             state, state_next;
    logic [PacketWidth-1:0] ru_packet_q;
    logic [IdxW-1:0]        grant_port_q;
    logic [IdxW-1:0]        rr_ptr;
    logic [TimerW-1:0]      timer      [TagSlots];
    logic [TimerW-1:0]      timer_next [TagSlots];

    logic [PacketWidth-1:0] head      [NumPorts];
    logic [SlotW-1:0]       head_slot [NumPorts];
    logic [NumPorts-1:0]    timer_blocked;
    logic [NumPorts-1:0]    req;
    logic [NumPorts-1:0]    pick_oh;
    logic [IdxW-1:0]        pick_idx;
    logic                   pick_found;
    logic                   accept, accept_red, fire, load;
    logic [SlotW-1:0]       accept_slot;

    // Timer values as they will be after this cycle, so a slot expiring now is usable now.
    always_comb begin
        accept      = (state == PRESENT) && bus.ru_ready;
        accept_red  = accept && is_reduction(ru_packet_q[ValidBitPos], ru_packet_q[OpPos+2 +: 2]);
        accept_slot = ru_packet_q[TagPos +: SlotW];
        for (int s = 0; s < TagSlots; s++) begin
            if (accept_red && (accept_slot == SlotW'(s))) begin
                timer_next[s] = TimerW'(HoldCycles);
            end else if (timer[s] != '0) begin
                timer_next[s] = timer[s] - TimerW'(1);
            end else begin
                timer_next[s] = '0;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            head[p] = bus.in_packet[p*PacketWidth +: PacketWidth];
        end
    end

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            head_slot[p]     = head[p][TagPos +: SlotW];
            timer_blocked[p] = is_reduction(head[p][ValidBitPos], head[p][OpPos+2 +: 2])
                               && (timer_next[head_slot[p]] != '0);
            req[p]           = !bus.in_empty[p] && !timer_blocked[p];
        end
    end

    rr_arbiter #(
        .NumPorts (NumPorts),
        .IdxW     (IdxW)
    ) u_rr_arbiter (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .found     (pick_found)
    );

    // An invalid head is popped but never loaded, so it leaves rr_ptr and state alone.
    always_comb begin
        state_next   = state;
        bus.in_rd_en = '0;
        fire         = 1'b0;
        case (state)
            IDLE:    fire = pick_found;
            PRESENT: fire = accept && pick_found;
            default: fire = 1'b0;
        endcase
        fire = fire && !rst;
        load = fire && head[pick_idx][ValidBitPos];
        if (fire) bus.in_rd_en = pick_oh;
        if (load) begin
            state_next = PRESENT;
        end else if (accept) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for registered state so every flop sees pre-edge values.
        if (rst) begin
            state        <= IDLE;
            ru_packet_q  <= '0;
            grant_port_q <= '0;
            rr_ptr       <= '0;
            // NOTE: the timer array must start cleared, so it is reset element by element.
            for (int s = 0; s < TagSlots; s++) timer[s] <= '0;
        end else begin
            state <= state_next;
            for (int s = 0; s < TagSlots; s++) timer[s] <= timer_next[s];
            if (load) begin
                ru_packet_q  <= head[pick_idx];
                grant_port_q <= pick_idx;
                rr_ptr       <= (pick_idx == IdxW'(NumPorts - 1)) ? '0 : pick_idx + IdxW'(1);
            end
        end
    end

    assign bus.ru_packet  = ru_packet_q;
    assign bus.ru_valid   = (state == PRESENT);
    assign bus.grant_port = grant_port_q;

`ifdef REDUCE_ARB_STATS_EN
    logic [15:0] stall_q [NumPorts];
    logic [15:0] hazard_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NumPorts; p++) stall_q[p] <= '0;
            hazard_q <= '0;
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                if (!bus.in_empty[p] && !bus.in_rd_en[p] && (stall_q[p] != '1)) begin
                    stall_q[p] <= stall_q[p] + 16'd1;
                end
            end
            if ((|(timer_blocked & ~bus.in_empty)) && (hazard_q != '1)) begin
                hazard_q <= hazard_q + 16'd1;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NumPorts; p++) stall_count[p*16 +: 16] = stall_q[p];
    end

    assign hazard_block_count = hazard_q;
`endif

endmodule
